// File: rtl/irq_vector_sequencer_if.sv
// Core-side bundle for the interrupt/reset entry sequencer: pins, decode pulses and step outputs.
// WAI_STP_EN adds the wai_req/stp_req decode pulses.
interface irq_vector_sequencer_if;
  logic        clock_running;
  logic        nmib_in;
  logic        irqb_in;
  logic        i_flag;
  logic        brk_req;
  logic        boundary;
`ifdef WAI_STP_EN
  logic        wai_req;
  logic        stp_req;
`endif
  logic        seq_busy;
  logic [2:0]  seq_step;
  logic [4:0]  vector_operations;
  logic [1:0]  push_sel;
  logic        dec_sp;
  logic [15:0] vector_addr;
  logic        b_flag_out;
  logic        set_i;
  logic        seq_done;
  logic        nmi_pending;

  modport master (
`ifdef WAI_STP_EN
    output wai_req, stp_req,
`endif
    output clock_running, nmib_in, irqb_in, i_flag, brk_req, boundary,
    input  seq_busy, seq_step, vector_operations, push_sel, dec_sp,
    input  vector_addr, b_flag_out, set_i, seq_done, nmi_pending
  );

  modport slave (
`ifdef WAI_STP_EN
    input  wai_req, stp_req,
`endif
    input  clock_running, nmib_in, irqb_in, i_flag, brk_req, boundary,
    output seq_busy, seq_step, vector_operations, push_sel, dec_sp,
    output vector_addr, b_flag_out, set_i, seq_done, nmi_pending
  );
endinterface

// File: rtl/irq_vector_sequencer.sv
// 65C02 reset/NMI/IRQ/BRK entry sequencer driving the seven-step vector microcode.
// Define WAI_STP_EN to build the WAI (wait) and STP (stop) states.
module irq_vector_sequencer #(
  parameter logic [15:0] VEC_NMI     = 16'hFFFA,
  parameter logic [15:0] VEC_RES     = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ     = 16'hFFFE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 fclk,
  input  logic                 resb,
  irq_vector_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_RES_HOLD = 3'd0,
    S_IDLE     = 3'd1,
    S_SEQ      = 3'd2
`ifdef WAI_STP_EN
    , S_WAIT   = 3'd3,
    S_STOP     = 3'd4
`endif
  } state_t;

  typedef enum logic [3:0] {
    TYPE_NONE = 4'b0000,
    TYPE_IRQ  = 4'b1001,
    TYPE_NMI  = 4'b1010,
    TYPE_RES  = 4'b1100
  } vec_type_t;

  state_t                 r_state, w_nextState;
  logic [2:0]             r_step, w_nextStep;
  vec_type_t              r_type, w_nextType;
  logic                   r_brk, w_nextBrk;
  logic                   r_hijack;
  logic [SYNC_STAGES-1:0] r_nmiSync;
  logic [SYNC_STAGES-1:0] r_irqSync;
  logic                   r_nmiPrev;
  logic                   r_nmiPending;
  logic                   r_brkPending;

  logic        w_nmiLevel, w_nmiEdge, w_irqLow, w_irqReq;
  logic        w_lastStep, w_nmiVector, w_grantBrk, w_stackStep;
  logic        w_busy, w_setI, w_done, w_bFlag;
  logic [4:0]  w_vecOps;
  logic [1:0]  w_pushSel;
  logic [15:0] w_base, w_vecAddr;

  assign w_nmiLevel  = r_nmiSync[SYNC_STAGES-1];
  assign w_nmiEdge   = r_nmiPrev & ~w_nmiLevel;
  assign w_irqLow    = ~r_irqSync[SYNC_STAGES-1];
  assign w_irqReq    = w_irqLow & ~bus.i_flag;
  assign w_lastStep  = (r_state == S_SEQ) && (r_step == 3'd6);
  // A hijacked IRQ/BRK entry fetches the NMI vector and so retires the NMI too.
  assign w_nmiVector = (r_type == TYPE_NMI) || r_hijack;

  always_comb begin
    w_nextState = r_state;
    w_nextStep  = r_step;
    w_nextType  = r_type;
    w_nextBrk   = r_brk;
    w_grantBrk  = 1'b0;
    if (bus.clock_running) begin
      case (r_state)
        S_RES_HOLD: begin
          w_nextState = S_SEQ;
          w_nextStep  = 3'd0;
          w_nextType  = TYPE_RES;
          w_nextBrk   = 1'b0;
        end
        S_IDLE: begin
`ifdef WAI_STP_EN
          if (bus.stp_req) begin
            w_nextState = S_STOP;
          end else if (bus.wai_req) begin
            w_nextState = S_WAIT;
          end else
`endif
          if (bus.boundary) begin
            if (r_nmiPending) begin
              w_nextState = S_SEQ;
              w_nextStep  = 3'd0;
              w_nextType  = TYPE_NMI;
              w_nextBrk   = 1'b0;
            end else if (r_brkPending) begin
              w_nextState = S_SEQ;
              w_nextStep  = 3'd0;
              w_nextType  = TYPE_IRQ;
              w_nextBrk   = 1'b1;
              w_grantBrk  = 1'b1;
            end else if (w_irqReq) begin
              w_nextState = S_SEQ;
              w_nextStep  = 3'd0;
              w_nextType  = TYPE_IRQ;
              w_nextBrk   = 1'b0;
            end
          end
        end
        S_SEQ: begin
          if (r_step == 3'd6) begin
            w_nextState = S_IDLE;
            w_nextStep  = 3'd0;
            w_nextType  = TYPE_NONE;
            w_nextBrk   = 1'b0;
          end else begin
            w_nextStep = r_step + 3'd1;
          end
        end
`ifdef WAI_STP_EN
        S_WAIT: begin
          if (r_nmiPending) begin
            w_nextState = S_SEQ;
            w_nextStep  = 3'd0;
            w_nextType  = TYPE_NMI;
            w_nextBrk   = 1'b0;
          end else if (w_irqLow) begin
            // A masked IRQ only wakes the core; it resumes fetch without vectoring.
            w_nextState = bus.i_flag ? S_IDLE : S_SEQ;
            w_nextStep  = 3'd0;
            w_nextType  = bus.i_flag ? TYPE_NONE : TYPE_IRQ;
            w_nextBrk   = 1'b0;
          end
        end
        S_STOP: begin
          w_nextState = S_STOP;
        end
`endif
        default: begin
          w_nextState = S_RES_HOLD;
        end
      endcase
    end
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_stackStep = (r_state == S_SEQ) && (r_step >= 3'd2) && (r_step <= 3'd4);
    w_vecOps    = 5'b00000;
    w_pushSel   = 2'b00;
    w_vecAddr   = 16'h0000;
    w_setI      = 1'b0;
    w_done      = 1'b0;
    w_bFlag     = 1'b0;
    w_base      = VEC_IRQ;
    if (w_nmiVector) begin
      w_base = VEC_NMI;
    end else if (r_type == TYPE_RES) begin
      w_base = VEC_RES;
    end
    if (r_state == S_SEQ) begin
      w_vecOps = {r_type, w_stackStep};
      w_bFlag  = r_brk;
      // Reset walks the stack pointer down but never writes memory.
      if (r_type != TYPE_RES) begin
        case (r_step)
          3'd2:    w_pushSel = 2'b01;
          3'd3:    w_pushSel = 2'b10;
          3'd4:    w_pushSel = 2'b11;
          default: w_pushSel = 2'b00;
        endcase
      end
      if (r_step == 3'd5) begin
        w_vecAddr = w_base;
      end else if (r_step == 3'd6) begin
        w_vecAddr = w_base + 16'd1;
        w_setI    = 1'b1;
        w_done    = 1'b1;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (!resb) begin
      r_state      <= S_RES_HOLD;
      r_step       <= 3'd0;
      r_type       <= TYPE_NONE;
      r_brk        <= 1'b0;
      r_hijack     <= 1'b0;
      r_nmiSync    <= '1;
      r_irqSync    <= '1;
      r_nmiPrev    <= 1'b1;
      r_nmiPending <= 1'b0;
      r_brkPending <= 1'b0;
    end else begin
      r_nmiSync[0] <= bus.nmib_in;
      r_irqSync[0] <= bus.irqb_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_nmiSync[k] <= r_nmiSync[k-1];
        r_irqSync[k] <= r_irqSync[k-1];
      end
      r_nmiPrev <= w_nmiLevel;

      // A fresh edge wins over retirement so an edge in step 6 is not lost.
      if (w_nmiEdge) begin
        r_nmiPending <= 1'b1;
      end else if (bus.clock_running && w_lastStep && w_nmiVector) begin
        r_nmiPending <= 1'b0;
      end

      if (bus.brk_req) begin
        r_brkPending <= 1'b1;
      end else if (w_grantBrk) begin
        r_brkPending <= 1'b0;
      end

      if (bus.clock_running && w_lastStep) begin
        r_hijack <= 1'b0;
      end else if ((r_state == S_SEQ) && (r_type == TYPE_IRQ) && (r_step <= 3'd3) &&
                   (w_nmiEdge || r_nmiPending)) begin
        r_hijack <= 1'b1;
      end

      r_state <= w_nextState;
      r_step  <= w_nextStep;
      r_type  <= w_nextType;
      r_brk   <= w_nextBrk;
    end
  end

  assign bus.seq_busy          = w_busy;
  assign bus.seq_step          = r_step;
  assign bus.vector_operations = w_vecOps;
  assign bus.push_sel          = w_pushSel;
  assign bus.dec_sp            = w_stackStep;
  assign bus.vector_addr       = w_vecAddr;
  assign bus.b_flag_out        = w_bFlag;
  assign bus.set_i             = w_setI;
  assign bus.seq_done          = w_done;
  assign bus.nmi_pending       = r_nmiPending;

endmodule
